// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic {
    SCAN = 1'b0,
    LOCK = 1'b1
  } scan_state_t;

  localparam int NUM_ROWS         = 4;
  localparam int NUM_COLS         = 4;
  localparam int DEFAULT_SCAN_DIV = 3000;

  // Isolates the lowest-index set bit; descending loop lets the lowest win.
  function automatic logic [NUM_COLS-1:0] lowest_set(input logic [NUM_COLS-1:0] v);
    logic [NUM_COLS-1:0] r;
    r = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows, locks onto the first pressed key
// found, and holds that report until the locked column is released.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_drive,
  output logic                key_pressed,
  output logic [NUM_ROWS-1:0] row_idx,
  output logic [NUM_COLS-1:0] col_idx
);

  localparam int          ROW_W    = $clog2(NUM_ROWS);
  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

  logic [NUM_COLS-1:0] col_sync;
  logic [NUM_COLS-1:0] col_act;
  logic [NUM_ROWS-1:0] row_onehot;

  scan_state_t         state_q,    state_d;
  logic [ROW_W-1:0]    row_q,      row_d;
  logic [15:0]         cnt_q,      cnt_d;
  logic [NUM_COLS-1:0] lock_col_q, lock_col_d;
  logic                key_q,      key_d;
  logic [NUM_ROWS-1:0] row_idx_q,  row_idx_d;
  logic [NUM_COLS-1:0] col_idx_q,  col_idx_d;

  sync_2ff #(
    .WIDTH   (NUM_COLS),
    .RST_VAL ({NUM_COLS{1'b1}})
  ) u_col_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (col_in),
    .q_o   (col_sync)
  );

  assign col_act    = ~col_sync;
  assign row_onehot = NUM_ROWS'(1) << row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      row_q      <= '0;
      cnt_q      <= '0;
      lock_col_q <= '0;
      key_q      <= 1'b0;
      row_idx_q  <= '0;
      col_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      lock_col_q <= lock_col_d;
      key_q      <= key_d;
      row_idx_q  <= row_idx_d;
      col_idx_q  <= col_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    lock_col_d = lock_col_q;
    key_d      = 1'b0;
    row_idx_d  = '0;
    col_idx_d  = '0;
    case (state_q)
      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (|col_act) begin
            // The sample that enters LOCK also raises the report on the same edge.
            state_d    = LOCK;
            lock_col_d = lowest_set(col_act);
            key_d      = 1'b1;
            row_idx_d  = row_onehot;
            col_idx_d  = lowest_set(col_act);
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOCK: begin
        cnt_d = '0;
        if (|(col_act & lock_col_q)) begin
          key_d     = 1'b1;
          row_idx_d = row_onehot;
          col_idx_d = lock_col_q;
        end else begin
          state_d    = SCAN;
          row_d      = row_q + 1'b1;
          lock_col_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  assign row_drive   = ~row_onehot;
  assign key_pressed = key_q;
  assign row_idx     = row_idx_q;
  assign col_idx     = col_idx_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a small scoreboard.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_drive;
  logic       key_pressed;
  logic [3:0] row_idx;
  logic [3:0] col_idx;

  logic [3:0] keys [4];
  logic [3:0] glitch = 4'b0000;

  int total = 0;
  int bad   = 0;

  logic [3:0] row_q_exp [$];
  logic [7:0] key_q_exp [$];

  keypad_scanner #(.SCAN_DIV(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_in      (col_in),
    .row_drive   (row_drive),
    .key_pressed (key_pressed),
    .row_idx     (row_idx),
    .col_idx     (col_idx)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    logic [3:0] act;
    act = glitch;
    for (int r = 0; r < 4; r++)
      if (!row_drive[r]) act = act | keys[r];
    col_in = ~act;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_key(input logic level, input int limit, output int n);
    n = 0;
    while (key_pressed !== level && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_row_change(input int limit, output int n);
    logic [3:0] prev;
    prev = row_drive;
    n = 0;
    while (row_drive === prev && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) keys[r] = 4'b0000;
  endtask

  initial begin
    int n;
    int since;
    logic [3:0] prev;
    logic [7:0] e;
    logic seen;

    clear_keys();
    #12;
    chk("reset_row_drive", 16'(row_drive), 16'h000e);
    chk("reset_key", 16'(key_pressed), 16'h0);
    chk("reset_idx", {8'h0, row_idx, col_idx}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle scan: five row steps, each 8 cycles apart.
    row_q_exp.push_back(4'b1101);
    row_q_exp.push_back(4'b1011);
    row_q_exp.push_back(4'b0111);
    row_q_exp.push_back(4'b1110);
    row_q_exp.push_back(4'b1101);
    prev = row_drive;
    since = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      since++;
      if (row_drive !== prev) begin
        if (row_q_exp.size() > 0) begin
          chk("scan_row", 16'(row_drive), 16'(row_q_exp.pop_front()));
        end else begin
          chk("scan_extra_step", 16'(row_drive), 16'(prev));
        end
        chk("scan_dwell", 16'(since), 16'd8);
        chk("scan_key_idle", 16'(key_pressed), 16'h0);
        prev = row_drive;
        since = 0;
      end
    end
    chk("scan_steps_left", 16'(row_q_exp.size()), 16'd0);

    // Row2/col1 held.
    keys[2] = 4'b0010;
    key_q_exp.push_back({4'b0100, 4'b0010});
    n = 0;
    while (row_drive !== 4'b1011 && n < 40) begin
      tick();
      n++;
    end
    chk("r2_reach_row", 16'(row_drive), 16'h000b);
    wait_key(1'b1, 40, n);
    chk("r2_latency", 16'(n), 16'd8);
    e = key_q_exp.pop_front();
    chk("r2_idx", {8'h0, row_idx, col_idx}, {8'h0, e});
    chk("r2_row_drive", 16'(row_drive), 16'h000b);
    for (int i = 0; i < 12; i++) tick();
    chk("r2_frozen", 16'(row_drive), 16'h000b);
    chk("r2_held", {11'h0, key_pressed, col_idx}, {11'h0, 1'b1, 4'b0010});

    // Release: fall within 3 cycles, next row gets a full dwell from 0.
    keys[2] = 4'b0000;
    wait_key(1'b0, 10, n);
    chk("r2_release_latency", 16'(n >= 1 && n <= 3), 16'h1);
    chk("r2_release_idx", {8'h0, row_idx, col_idx}, 16'h0);
    chk("r2_next_row", 16'(row_drive), 16'h0007);
    wait_row_change(20, n);
    chk("r2_next_dwell", 16'(n), 16'd8);
    chk("r2_wrap_row", 16'(row_drive), 16'h000e);

    // Row1, col1 and col3 together: lowest column wins and owns the lock.
    keys[1] = 4'b1010;
    key_q_exp.push_back({4'b0010, 4'b0010});
    wait_key(1'b1, 40, n);
    chk("multi_timeout", 16'(n < 40), 16'h1);
    e = key_q_exp.pop_front();
    chk("multi_idx", {8'h0, row_idx, col_idx}, {8'h0, e});
    keys[1] = 4'b0010;
    for (int i = 0; i < 6; i++) tick();
    chk("multi_col3_release", {7'h0, key_pressed, row_drive, col_idx}, {7'h0, 1'b1, 4'b1101, 4'b0010});
    keys[1] = 4'b0000;
    wait_key(1'b0, 10, n);
    chk("multi_col1_release", 16'(n >= 1 && n <= 3), 16'h1);
    chk("multi_next_row", 16'(row_drive), 16'h000b);

    // Reset while locked.
    keys[0] = 4'b0001;
    key_q_exp.push_back({4'b0001, 4'b0001});
    wait_key(1'b1, 40, n);
    chk("rst_lock_timeout", 16'(n < 40), 16'h1);
    e = key_q_exp.pop_front();
    chk("rst_lock_idx", {8'h0, row_idx, col_idx}, {8'h0, e});
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out", {3'h0, key_pressed, row_idx, col_idx, row_drive}, {3'h0, 1'b0, 4'h0, 4'h0, 4'he});
    clear_keys();
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_row", 16'(row_drive), 16'h000e);
    rst_n = 1'b1;
    wait_row_change(20, n);
    chk("rst_resume_dwell", 16'(n), 16'd8);
    chk("rst_resume_row", 16'(row_drive), 16'h000d);

    // Two-cycle column glitch well away from the sampling cycle.
    tick();
    glitch = 4'b0001;
    tick();
    tick();
    glitch = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (key_pressed) seen = 1'b1;
    end
    chk("glitch_no_lock", 16'(seen), 16'h0);
    chk("glitch_idx", {8'h0, row_idx, col_idx}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
